// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with a load/store front end: four interleaved byte banks,
// byte/half/word accesses, and a two-cycle split for accesses that cross a word row.
module data_mem_lsu #(
    parameter int ADDR_BITS        = 12,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int ROW_BITS = ADDR_BITS - 2;
    localparam int DEPTH    = 1 << ROW_BITS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [7:0] mem [4][DEPTH];

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic                 we_q, we_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0][7:0]      hold_q, hold_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic                 resp_err_q, resp_err_d;

    logic                 split_active;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [1:0]           cur_size;
    logic                 cur_unsigned;
    logic                 cur_we;
    logic [31:0]          cur_wdata;
    logic [1:0]           off;
    logic [2:0]           nbytes;
    logic [ROW_BITS-1:0]  row_lo, row_hi, acc_row;
    logic                 misaligned, req_err, crossing, accept;
    logic [3:0][1:0]      lane;
    logic [3:0]           bank_en, bank_hi, wr_en;
    logic [3:0][7:0]      rd_byte, wr_byte, merged, raw;
    logic [31:0]          load_data;
    logic                 unused_addr_bits;

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // the response is a single resp_valid pulse with no backpressure.
    assign req_ready        = (state_q == ST_IDLE) && !rst;
    assign accept           = req_valid && req_ready;
    assign unused_addr_bits = ^req_addr[31:ADDR_BITS];

    assign split_active = (state_q == ST_SPLIT);
    assign cur_addr     = split_active ? addr_q     : req_addr[ADDR_BITS-1:0];
    assign cur_size     = split_active ? size_q     : req_size;
    assign cur_unsigned = split_active ? unsigned_q : req_unsigned;
    assign cur_we       = split_active ? we_q       : req_we;
    assign cur_wdata    = split_active ? wdata_q    : req_wdata;

    assign off     = cur_addr[1:0];
    assign row_lo  = cur_addr[ADDR_BITS-1:2];
    assign row_hi  = row_lo + 1'b1;
    assign acc_row = split_active ? row_hi : row_lo;

    always_comb begin
        case (cur_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign misaligned = ((cur_size == 2'b01) && off[0]) || ((cur_size == 2'b10) && (off != 2'b00));
    assign req_err    = (cur_size == 2'b11) || (!ALLOW_MISALIGNED && misaligned);
    assign crossing   = ({1'b0, off} + nbytes) > 3'd4;

    // Bank b holds access byte (b - off) mod 4; banks below off belong to the next row.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lane[b]    = 2'(b) - off;
            bank_en[b] = {1'b0, lane[b]} < nbytes;
            bank_hi[b] = 2'(b) < off;
            rd_byte[b] = mem[b][acc_row];
            wr_byte[b] = cur_wdata[{lane[b], 3'b000} +: 8];
            wr_en[b]   = !rst && cur_we && bank_en[b] &&
                         (split_active ? bank_hi[b] : (accept && !req_err && !bank_hi[b]));
            merged[b]  = (split_active && !bank_hi[b]) ? hold_q[b] : rd_byte[b];
        end
    end

    always_comb begin
        logic [1:0] sel;
        for (int i = 0; i < 4; i++) begin
            sel    = off + 2'(i);
            raw[i] = merged[sel];
        end
    end

    always_comb begin
        case (cur_size)
            2'b00:   load_data = {{24{!cur_unsigned && raw[0][7]}}, raw[0]};
            2'b01:   load_data = {{16{!cur_unsigned && raw[1][7]}}, raw[1], raw[0]};
            default: load_data = raw;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        hold_d       = hold_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (split_active) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = cur_we ? 32'h0 : load_data;
        end else if (accept) begin
            if (req_err) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = 32'h0;
            end else if (crossing) begin
                state_d    = ST_SPLIT;
                addr_d     = cur_addr;
                size_d     = cur_size;
                unsigned_d = cur_unsigned;
                we_d       = cur_we;
                wdata_d    = cur_wdata;
                hold_d     = rd_byte;
            end else begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = cur_we ? 32'h0 : load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            hold_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            hold_q       <= hold_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory contents survive reset; wr_en already blocks writes while rst is high.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem[b][acc_row] <= wr_byte[b];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule
